mem_access_stage: RTL and testbench

Memory-access stage of the SEQ RV64 core. It sits directly downstream of the execute stage and consumes its 64-bit ALU result as the effective address, with `rd2` as store data. It runs a request/grant/response handshake with the data memory and performs byte-lane alignment plus load sign/zero extension. It delivers the write-back value downstream over a valid/ready handshake, and passes non-memory instructions through with one cycle of latency.

---
 rtl/mem_stage_pkg.sv | 56 +++++
 rtl/mem_access_stage_load_align.sv | 34 +++
 rtl/mem_access_stage.sv | 213 +++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access stage.
//   state_e      : stage FSM state
//   F3_*         : load/store funct3 encodings
//   MASK_*       : byte-strobe masks per access size
//   size_mask()  : strobe mask for a size code
//   low_mask()   : address bits below the natural alignment of a size code
package mem_stage_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned STRB_W = 8;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  localparam logic [STRB_W-1:0] MASK_B = 8'h01;
  localparam logic [STRB_W-1:0] MASK_H = 8'h03;
  localparam logic [STRB_W-1:0] MASK_W = 8'h0F;
  localparam logic [STRB_W-1:0] MASK_D = 8'hFF;

  function automatic logic [STRB_W-1:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    return MASK_B;
      2'd1:    return MASK_H;
      2'd2:    return MASK_W;
      default: return MASK_D;
    endcase
  endfunction

  function automatic logic [2:0] low_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    return 3'b000;
      2'd1:    return 3'b001;
      2'd2:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// load_align: selects the addressed lane of a read doubleword and
// sign- or zero-extends it according to the load funct3.
//   rdata     in  64 : doubleword returned by data memory
//   addr_lo   in  3  : byte offset of the access within the doubleword
//   funct3    in  3  : load size/signedness
//   load_data out 64 : extended load value (0 for an unused code)
module load_align
  import mem_stage_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      addr_lo,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] load_data
);

  logic [XLEN-1:0] lane;

  // Shift the addressed byte down to bit 0, then extend.
  always_comb begin
    lane      = rdata >> {addr_lo, 3'b000};
    load_data = '0;
    case (funct3)
      F3_LB:   load_data = {{56{lane[7]}},  lane[7:0]};
      F3_LH:   load_data = {{48{lane[15]}}, lane[15:0]};
      F3_LW:   load_data = {{32{lane[31]}}, lane[31:0]};
      F3_LD:   load_data = lane;
      F3_LBU:  load_data = {56'd0, lane[7:0]};
      F3_LHU:  load_data = {48'd0, lane[15:0]};
      F3_LWU:  load_data = {32'd0, lane[31:0]};
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: memory-access stage of the SEQ RV64 core.
// Takes the ALU result as effective address and rd2 as store data, runs a
// req/gnt/rvalid handshake with data memory, aligns store lanes and
// extends loads, and returns the write-back value over valid/ready.
// Non-memory instructions pass alu_result through with one cycle latency.
//   MAX_WAIT            : cycles allowed in REQ+WAIT before a bus timeout
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : upstream handshake (ready only in IDLE)
//   mem_read/mem_write  : load / store flags (store wins if both)
//   funct3              : access size and signedness
//   alu_result, rd2     : effective address / pass-through value, store data
//   dmem_*              : data-memory request/grant/response interface
//   out_valid/out_ready : downstream handshake
//   out_data, out_err   : write-back value, error (illegal/misaligned/timeout)
// Build option: MEM_MISALIGN_TRAP_EN makes non-naturally-aligned accesses
// an error; otherwise the low address bits are aligned down silently.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   alu_result,
  input  logic [XLEN-1:0]   rd2,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic [STRB_W-1:0] dmem_wstrb,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_data,
  output logic              out_err
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [XLEN-1:0]     addr_q, addr_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [2:0]          f3_q, f3_d;
  logic [2:0]          off_q, off_d;
  logic                wr_q, wr_d;
  logic                in_ready_q, in_ready_d;
  logic                dmem_req_q, dmem_req_d;
  logic                dmem_we_q, dmem_we_d;
  logic                out_valid_q, out_valid_d;
  logic [XLEN-1:0]     out_data_q, out_data_d;
  logic                out_err_q, out_err_d;

  logic [XLEN-1:0]     load_data, resp_data;
  logic                is_mem, is_store, legal, misalign, timeout;
  logic [2:0]          low, in_off;

  load_align u_load_align (
    .rdata     (dmem_rdata),
    .addr_lo   (off_q),
    .funct3    (f3_q),
    .load_data (load_data)
  );

  // Decode the incoming instruction; the lane offset is always aligned down.
  always_comb begin
    is_store = mem_write;
    is_mem   = mem_read | mem_write;
    low      = low_mask(funct3[1:0]);
    legal    = is_store ? ~funct3[2] : (funct3 != 3'b111);
    in_off   = alu_result[2:0] & ~low;
`ifdef MEM_MISALIGN_TRAP_EN
    misalign = (alu_result[2:0] & low) != 3'b000;
`else
    misalign = 1'b0;
`endif
  end

  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign timeout   = (cnt_inc == CNT_W'(MAX_WAIT));
  assign resp_data = wr_q ? '0 : load_data;

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    f3_d       = f3_q;
    off_d      = off_q;
    wr_d       = wr_q;
    out_data_d = out_data_q;
    out_err_d  = out_err_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          addr_d  = {alu_result[XLEN-1:3], 3'b000};
          f3_d    = funct3;
          off_d   = in_off;
          wr_d    = is_store;
          wstrb_d = is_store ? STRB_W'(size_mask(funct3[1:0]) << in_off) : '0;
          wdata_d = is_store ? (rd2 << {in_off, 3'b000}) : '0;
          if (!is_mem) begin
            state_d    = ST_RESP;
            out_data_d = alu_result;
            out_err_d  = 1'b0;
          end else if (!legal || misalign) begin
            state_d    = ST_RESP;
            out_data_d = '0;
            out_err_d  = 1'b1;
          end else begin
            state_d = ST_REQ;
            cnt_d   = '0;
          end
        end
      end
      ST_REQ: begin
        cnt_d = cnt_inc;
        // A response arriving with the grant completes in one step.
        if (dmem_gnt && dmem_rvalid) begin
          state_d    = ST_RESP;
          out_data_d = resp_data;
          out_err_d  = 1'b0;
        end else if (dmem_gnt) begin
          state_d = ST_WAIT;
        end else if (timeout) begin
          state_d    = ST_RESP;
          out_data_d = '0;
          out_err_d  = 1'b1;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_inc;
        if (dmem_rvalid) begin
          state_d    = ST_RESP;
          out_data_d = resp_data;
          out_err_d  = 1'b0;
        end else if (timeout) begin
          state_d    = ST_RESP;
          out_data_d = '0;
          out_err_d  = 1'b1;
        end
      end
      ST_RESP: begin
        if (out_ready) begin
          state_d    = ST_IDLE;
          out_data_d = '0;
          out_err_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d  = (state_d == ST_IDLE);
    dmem_req_d  = (state_d == ST_REQ);
    dmem_we_d   = (state_d == ST_REQ) && wr_d;
    out_valid_d = (state_d == ST_RESP);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      f3_q        <= '0;
      off_q       <= '0;
      wr_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      dmem_req_q  <= 1'b0;
      dmem_we_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      wr_q        <= wr_d;
      in_ready_q  <= in_ready_d;
      dmem_req_q  <= dmem_req_d;
      dmem_we_q   <= dmem_we_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign dmem_wstrb = wstrb_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_err    = out_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: stimulus pushes expected bus
// requests and write-back results; a memory responder and an output
// monitor pop and compare. A second instance with MAX_WAIT=4 and no
// grant exercises the timeout and mid-request reset paths.
`timescale 1ns/1ps
module tb_mem_access_stage;

  typedef struct {
    logic [63:0] data;
    logic        err;
    int          lat;
  } out_t;

  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic [7:0]  wstrb;
    logic [63:0] wdata;
  } bus_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, in_ready, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [63:0] alu_result, rd2;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [7:0]  dmem_wstrb;
  logic        out_valid, out_ready, out_err;
  logic [63:0] out_data;

  logic        t_in_valid, t_in_ready, t_dmem_req, t_dmem_we, t_dmem_gnt, t_dmem_rvalid;
  logic [63:0] t_dmem_addr, t_dmem_wdata, t_out_data;
  logic [7:0]  t_dmem_wstrb;
  logic        t_out_valid, t_out_ready, t_out_err;

  mem_access_stage u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .alu_result(alu_result), .rd2(rd2),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
  );

  mem_access_stage #(.MAX_WAIT(4)) u_to (
    .clk(clk), .rst_n(rst_n), .in_valid(t_in_valid), .in_ready(t_in_ready),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .alu_result(alu_result), .rd2(rd2),
    .dmem_req(t_dmem_req), .dmem_we(t_dmem_we), .dmem_addr(t_dmem_addr),
    .dmem_wdata(t_dmem_wdata), .dmem_wstrb(t_dmem_wstrb), .dmem_gnt(t_dmem_gnt),
    .dmem_rvalid(t_dmem_rvalid), .dmem_rdata(dmem_rdata),
    .out_valid(t_out_valid), .out_ready(t_out_ready), .out_data(t_out_data), .out_err(t_out_err)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_cyc = 0;

  out_t exp_out[$];
  bus_t exp_bus[$];

  int          gnt_delay = 0;
  bit          same_cyc = 1'b0;
  bit          spur_rv = 1'b0;
  int          bp_cnt = 0;
  logic [63:0] mem_rdata = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_valid && in_ready) acc_cyc <= cyc;
  end

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checkint(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Memory responder: checks each new request against the bus queue,
  // checks address stability while stalled, grants after gnt_delay cycles.
  initial begin : responder
    int          hold;
    bit          seen;
    bit          pend;
    logic [63:0] first_addr;
    bus_t        b;
    hold = 0; seen = 1'b0; pend = 1'b0; first_addr = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    forever begin
      @(negedge clk);
      dmem_gnt = 1'b0;
      dmem_rvalid = 1'b0;
      if (pend) begin
        dmem_rvalid = 1'b1;
        dmem_rdata = mem_rdata;
        pend = 1'b0;
      end else if (dmem_req) begin
        if (!seen) begin
          seen = 1'b1;
          hold = 0;
          first_addr = dmem_addr;
          if (exp_bus.size() == 0) begin
            checks++; errors++;
            $display("FAIL bus_req: unexpected request to %h", dmem_addr);
          end else begin
            b = exp_bus.pop_front();
            check64("bus_addr", dmem_addr, b.addr);
            check1("bus_we", dmem_we, b.we);
            if (b.we) begin
              check64("bus_wstrb", 64'(dmem_wstrb), 64'(b.wstrb));
              check64("bus_wdata", dmem_wdata, b.wdata);
            end
          end
        end else begin
          check64("stall_addr", dmem_addr, first_addr);
        end
        if (hold < gnt_delay) begin
          hold++;
        end else begin
          dmem_gnt = 1'b1;
          seen = 1'b0;
          if (same_cyc) begin
            dmem_rvalid = 1'b1;
            dmem_rdata = mem_rdata;
          end else begin
            pend = 1'b1;
          end
        end
      end else if (spur_rv) begin
        dmem_gnt = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata = '1;
      end
    end
  end

  // Output monitor: compares every valid cycle against the queue head,
  // checks latency on the first valid cycle, applies back-pressure.
  initial begin : monitor
    bit   first;
    out_t e;
    first = 1'b1;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (exp_out.size() == 0) begin
          checks++; errors++;
          $display("FAIL out_unexpected: data %h err %b", out_data, out_err);
          out_ready = 1'b1;
        end else begin
          e = exp_out[0];
          check64("out_data", out_data, e.data);
          check1("out_err", out_err, e.err);
          check1("in_ready_busy", in_ready, 1'b0);
          if (first && e.lat != 0) checkint("latency", cyc - acc_cyc, e.lat);
          first = 1'b0;
          if (bp_cnt > 0) begin
            out_ready = 1'b0;
            bp_cnt--;
          end else begin
            out_ready = 1'b1;
            void'(exp_out.pop_front());
            first = 1'b1;
          end
        end
      end
    end
  end

  task automatic issue(input bit mr, input bit mw, input logic [2:0] f3,
                       input logic [63:0] addr, input logic [63:0] wd,
                       input logic [63:0] rdat, input int gd, input bit sc,
                       input int bp, input out_t eo, input bit has_bus, input bus_t eb);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL issue_wait: in_ready low for %0d cycles", w);
    end
    gnt_delay = gd; same_cyc = sc; mem_rdata = rdat; bp_cnt = bp;
    exp_out.push_back(eo);
    if (has_bus) exp_bus.push_back(eb);
    mem_read = mr; mem_write = mw; funct3 = f3; alu_result = addr; rd2 = wd;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pt(input logic [63:0] v, input int bp);
    issue(1'b0, 1'b0, 3'b000, v, 64'h0, 64'h0, 0, 1'b0, bp,
          '{v, 1'b0, 1}, 1'b0, '{64'h0, 1'b0, 8'h0, 64'h0});
  endtask

  task automatic ld(input logic [2:0] f3, input logic [63:0] addr, input logic [63:0] rdat,
                    input logic [63:0] expd, input int gd, input bit sc, input int lat);
    issue(1'b1, 1'b0, f3, addr, 64'h0, rdat, gd, sc, 0,
          '{expd, 1'b0, lat}, 1'b1, '{addr & ~64'h7, 1'b0, 8'h0, 64'h0});
  endtask

  task automatic st(input bit mr, input logic [2:0] f3, input logic [63:0] addr,
                    input logic [63:0] wd, input logic [63:0] baddr,
                    input logic [7:0] strb, input logic [63:0] wdat);
    issue(mr, 1'b1, f3, addr, wd, 64'h0, 0, 1'b0, 0,
          '{64'h0, 1'b0, 3}, 1'b1, '{baddr, 1'b1, strb, wdat});
  endtask

  task automatic err_op(input bit mr, input bit mw, input logic [2:0] f3, input logic [63:0] addr);
    issue(mr, mw, f3, addr, 64'h0, 64'h0, 0, 1'b0, 0,
          '{64'h0, 1'b1, 1}, 1'b0, '{64'h0, 1'b0, 8'h0, 64'h0});
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((exp_out.size() != 0 || exp_bus.size() != 0 || !in_ready) && w < 200) begin
      @(negedge clk);
      w++;
    end
    checkint("drain_pending", exp_out.size() + exp_bus.size(), 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    int reqc;
    rst_n = 1'b0; in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    funct3 = 3'b000; alu_result = '0; rd2 = '0;
    t_in_valid = 1'b0; t_dmem_gnt = 1'b0; t_dmem_rvalid = 1'b0; t_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    check1("rst_in_ready", in_ready, 1'b1);
    check1("rst_out_valid", out_valid, 1'b0);
    check1("rst_dmem_req", dmem_req, 1'b0);
    check1("rst_dmem_we", dmem_we, 1'b0);
    check64("rst_out_data", out_data, 64'h0);
    check1("rst_out_err", out_err, 1'b0);
    check64("rst_dmem_addr", dmem_addr, 64'h0);

    pt(64'h1234, 0);
    ld(3'b000, 64'h1003, 64'h00000000_80FF0000, 64'hFFFFFFFF_FFFFFF80, 0, 1'b0, 3);
    ld(3'b100, 64'h1003, 64'h00000000_80FF0000, 64'h00000000_00000080, 0, 1'b0, 3);
    st(1'b0, 3'b001, 64'h2006, 64'h0000_0000_0000_ABCD, 64'h2000, 8'hC0, 64'hABCD0000_00000000);
    ld(3'b011, 64'h4000, 64'h11223344_55667788, 64'h11223344_55667788, 3, 1'b0, 6);
    pt(64'hDEAD_BEEF_0000_0001, 2);
    ld(3'b101, 64'h5006, 64'hBEEF0000_00000000, 64'h00000000_0000BEEF, 0, 1'b0, 3);
    ld(3'b110, 64'h5004, 64'hFEDCBA98_00000000, 64'h00000000_FEDCBA98, 0, 1'b0, 3);
    ld(3'b001, 64'h5002, 64'h00000000_80010000, 64'hFFFFFFFF_FFFF8001, 0, 1'b0, 3);
    st(1'b0, 3'b000, 64'h6005, 64'h12345678_9ABCDE5A, 64'h6000, 8'h20, 64'hBCDE5A00_00000000);
    st(1'b0, 3'b011, 64'h7000, 64'h01234567_89ABCDEF, 64'h7000, 8'hFF, 64'h01234567_89ABCDEF);
    st(1'b1, 3'b011, 64'h7008, 64'hCAFEF00D_12345678, 64'h7008, 8'hFF, 64'hCAFEF00D_12345678);
    err_op(1'b1, 1'b0, 3'b111, 64'h7100);
    err_op(1'b0, 1'b1, 3'b100, 64'h7200);
    ld(3'b011, 64'h8000, 64'h0F0E0D0C_0B0A0908, 64'h0F0E0D0C_0B0A0908, 0, 1'b1, 2);
`ifdef MEM_MISALIGN_TRAP_EN
    err_op(1'b1, 1'b0, 3'b010, 64'h3002);
    err_op(1'b0, 1'b1, 3'b011, 64'h7004);
`else
    ld(3'b010, 64'h3002, 64'hAAAAAAAA_87654321, 64'hFFFFFFFF_87654321, 0, 1'b0, 3);
    st(1'b0, 3'b011, 64'h7004, 64'h55AA55AA_00FF00FF, 64'h7000, 8'hFF, 64'h55AA55AA_00FF00FF);
`endif
    drain();

    // Spurious gnt/rvalid while idle and in RESP are ignored.
    spur_rv = 1'b1;
    pt(64'h55AA, 1);
    drain();
    spur_rv = 1'b0;

    // Timeout instance: grant never arrives.
    @(negedge clk);
    mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b011; alu_result = 64'h9008;
    t_out_ready = 1'b0;
    check1("to_in_ready", t_in_ready, 1'b1);
    t_in_valid = 1'b1;
    @(negedge clk);
    t_in_valid = 1'b0;
    check64("to_addr", t_dmem_addr, 64'h9008);
    check1("to_we", t_dmem_we, 1'b0);
    n = 0; reqc = 0;
    while (!t_out_valid && n < 50) begin
      if (t_dmem_req) reqc++;
      @(negedge clk);
      n++;
    end
    check1("to_out_valid", t_out_valid, 1'b1);
    checkint("to_req_cycles", reqc, 4);
    check1("to_out_err", t_out_err, 1'b1);
    check64("to_out_data", t_out_data, 64'h0);
    check1("to_req_dropped", t_dmem_req, 1'b0);
    t_dmem_rvalid = 1'b1;
    @(negedge clk);
    t_dmem_rvalid = 1'b0;
    check64("to_late_data", t_out_data, 64'h0);
    check1("to_late_err", t_out_err, 1'b1);
    check1("to_busy", t_in_ready, 1'b0);
    t_out_ready = 1'b1;
    @(negedge clk);
    check1("to_idle_valid", t_out_valid, 1'b0);
    check1("to_idle_ready", t_in_ready, 1'b1);
    t_dmem_rvalid = 1'b1;
    @(negedge clk);
    t_dmem_rvalid = 1'b0;
    @(negedge clk);
    check1("to_idle_rvalid_ignored", t_out_valid, 1'b0);

    // Reset while a request is outstanding.
    mem_read = 1'b0; mem_write = 1'b1; funct3 = 3'b011; alu_result = 64'hA000; rd2 = 64'h1;
    t_in_valid = 1'b1;
    @(negedge clk);
    t_in_valid = 1'b0;
    @(negedge clk);
    check1("rr_req_active", t_dmem_req, 1'b1);
    check1("rr_we_active", t_dmem_we, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check1("rr_req_cleared", t_dmem_req, 1'b0);
    check1("rr_in_ready", t_in_ready, 1'b1);
    check1("rr_out_valid", t_out_valid, 1'b0);
    check64("rr_wdata", t_dmem_wdata, 64'h0);
    check64("rr_wstrb", 64'(t_dmem_wstrb), 64'h0);
    check1("rr_main_idle", in_ready, 1'b1);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
